sequenciador_entrada: RTL and testbench

Input-sequencing front end that produces the `entrada_numero`, `entrada_operacao` and `executar` request strobes consumed by the clock controller and the ULA datapath. It takes raw push-button levels and switch data, synchronizes them, detects presses, and enforces the entry order operand A → operation → operand B → execute. It captures operands and opcode into registers, then waits for the ULA's completion or a timeout. It sits between the board I/O and the clock controller / ULA.

---
 rtl/sequenciador_entrada.sv | 190 +++++++++++++++++++
 tb/tb_sequenciador_entrada.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequenciador_entrada.sv
// sequenciador_entrada: push-button front end and entry-order FSM.
// The buttons are synchronized and edge-detected here. The FSM enforces the
// order operand A, operation, operand B, execute, and it captures the operands
// and the opcode. It issues one-cycle strobes to the clock controller and the
// ULA, then waits in EXEC for ula_pronto or for a timeout.
module sequenciador_entrada #(
   parameter int LARGURA = 8,
   parameter int TIMEOUT = 16
) (
   input  logic               clk_in,
   input  logic               rst,
   input  logic               btn_numero,
   input  logic               btn_operacao,
   input  logic               btn_executar,
   input  logic [LARGURA-1:0] dado_in,
   input  logic [2:0]         op_in,
   input  logic               ula_pronto,
   output logic               entrada_numero,
   output logic               entrada_operacao,
   output logic               executar,
   output logic [LARGURA-1:0] operando_a,
   output logic [LARGURA-1:0] operando_b,
   output logic [2:0]         operacao,
   output logic [2:0]         estado,
   output logic               erro
);

   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(TIMEOUT - 1);

   // Press vector bit positions: [0] numero, [1] operacao, [2] executar.
   localparam logic [2:0] P_NUM = 3'b001;
   localparam logic [2:0] P_OPE = 3'b010;
   localparam logic [2:0] P_EXE = 3'b100;

   typedef enum logic [2:0] {
      ESPERA_A  = 3'd0,
      ESPERA_OP = 3'd1,
      ESPERA_B  = 3'd2,
      PRONTO    = 3'd3,
      EXEC      = 3'd4
   } estado_t;

   logic [2:0]         btn_raw;
   logic [2:0]         sync1_q, sync1_d;
   logic [2:0]         sync2_q, sync2_d;
   logic [2:0]         prev_q, prev_d;
   logic [2:0]         press;

   estado_t            estado_q, estado_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [LARGURA-1:0] op_a_q, op_a_d;
   logic [LARGURA-1:0] op_b_q, op_b_d;
   logic [2:0]         opc_q, opc_d;
   logic               ent_num_q, ent_num_d;
   logic               ent_ope_q, ent_ope_d;
   logic               exe_q, exe_d;
   logic               erro_q, erro_d;

   assign btn_raw = {btn_executar, btn_operacao, btn_numero};
   // A press is a rising edge seen after the two-flop synchronizer.
   assign press   = sync2_q & ~prev_q;

   // Two-stage synchronizer followed by the previous-level register used for edge detection.
   always_comb begin
      sync1_d = btn_raw;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
   end

   // Entry-order FSM: accepts exactly one press per cycle, captures data, and flags errors.
   always_comb begin
      estado_d  = estado_q;
      cnt_d     = cnt_q;
      op_a_d    = op_a_q;
      op_b_d    = op_b_q;
      opc_d     = opc_q;
      ent_num_d = 1'b0;
      ent_ope_d = 1'b0;
      exe_d     = 1'b0;
      erro_d    = erro_q;

      case (estado_q)
         ESPERA_A: begin
            if (press == P_NUM) begin
               op_a_d    = dado_in;
               ent_num_d = 1'b1;
               erro_d    = 1'b0;
               estado_d  = ESPERA_OP;
            end else if (press != 3'b000) begin
               erro_d = 1'b1;
            end
         end
         ESPERA_OP: begin
            if (press == P_OPE) begin
               opc_d     = op_in;
               ent_ope_d = 1'b1;
               erro_d    = 1'b0;
               estado_d  = ESPERA_B;
            end else if (press != 3'b000) begin
               erro_d = 1'b1;
            end
         end
         ESPERA_B: begin
            if (press == P_NUM) begin
               op_b_d    = dado_in;
               ent_num_d = 1'b1;
               erro_d    = 1'b0;
               estado_d  = PRONTO;
            end else if (press == P_OPE) begin
               // The user may still change the operation before giving B.
               opc_d     = op_in;
               ent_ope_d = 1'b1;
               erro_d    = 1'b0;
            end else if (press != 3'b000) begin
               erro_d = 1'b1;
            end
         end
         PRONTO: begin
            if (press == P_NUM) begin
               op_b_d    = dado_in;
               ent_num_d = 1'b1;
               erro_d    = 1'b0;
            end else if (press == P_EXE) begin
               exe_d    = 1'b1;
               erro_d   = 1'b0;
               cnt_d    = '0;
               estado_d = EXEC;
            end else if (press != 3'b000) begin
               erro_d = 1'b1;
            end
         end
         EXEC: begin
            // Presses are ignored here. On the last cycle, ula_pronto takes priority over the timeout.
            if (ula_pronto) begin
               estado_d = ESPERA_A;
            end else if (cnt_q == CNT_FIM) begin
               erro_d   = 1'b1;
               estado_d = ESPERA_A;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            estado_d = ESPERA_A;
         end
      endcase
   end

   // State, data and strobe registers. Buttons reset high so that a button held through reset does not count as a press.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         sync1_q   <= 3'b111;
         sync2_q   <= 3'b111;
         prev_q    <= 3'b111;
         estado_q  <= ESPERA_A;
         cnt_q     <= '0;
         op_a_q    <= '0;
         op_b_q    <= '0;
         opc_q     <= '0;
         ent_num_q <= 1'b0;
         ent_ope_q <= 1'b0;
         exe_q     <= 1'b0;
         erro_q    <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         prev_q    <= prev_d;
         estado_q  <= estado_d;
         cnt_q     <= cnt_d;
         op_a_q    <= op_a_d;
         op_b_q    <= op_b_d;
         opc_q     <= opc_d;
         ent_num_q <= ent_num_d;
         ent_ope_q <= ent_ope_d;
         exe_q     <= exe_d;
         erro_q    <= erro_d;
      end
   end

   assign entrada_numero   = ent_num_q;
   assign entrada_operacao = ent_ope_q;
   assign executar         = exe_q;
   assign operando_a       = op_a_q;
   assign operando_b       = op_b_q;
   assign operacao         = opc_q;
   assign estado           = estado_q;
   assign erro             = erro_q;

endmodule

// File: tb/tb_sequenciador_entrada.sv
// Testbench for sequenciador_entrada. A reference model compares every output on every
// cycle, and directed scenarios add hand-computed literal expectations.
module tb_sequenciador_entrada;

   localparam int LARGURA = 8;
   localparam int TIMEOUT = 16;

   logic               clk_in;
   logic               rst;
   logic               btn_numero, btn_operacao, btn_executar;
   logic [LARGURA-1:0] dado_in;
   logic [2:0]         op_in;
   logic               ula_pronto;
   logic               entrada_numero, entrada_operacao, executar;
   logic [LARGURA-1:0] operando_a, operando_b;
   logic [2:0]         operacao, estado;
   logic               erro;

   sequenciador_entrada #(.LARGURA(LARGURA), .TIMEOUT(TIMEOUT)) dut (
      .clk_in           (clk_in),
      .rst              (rst),
      .btn_numero       (btn_numero),
      .btn_operacao     (btn_operacao),
      .btn_executar     (btn_executar),
      .dado_in          (dado_in),
      .op_in            (op_in),
      .ula_pronto       (ula_pronto),
      .entrada_numero   (entrada_numero),
      .entrada_operacao (entrada_operacao),
      .executar         (executar),
      .operando_a       (operando_a),
      .operando_b       (operando_b),
      .operacao         (operacao),
      .estado           (estado),
      .erro             (erro)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(negedge clk_in);
   endtask

   // Reference model. Button levels are kept as a history of samples taken at each edge.
   // A press seen at edge n means the level was high at edge n-2 and low at edge n-3.
   // Reset fills the history with highs.
   bit [2:0]     smp[$];
   int           m_step;
   int           m_age;
   logic [7:0]   m_a, m_b;
   logic [2:0]   m_op;
   logic         m_err, m_num, m_ope, m_exe;

   always @(posedge clk_in) begin
      bit [2:0] p;
      if (rst) begin
         smp.delete();
         smp.push_back(3'b111); smp.push_back(3'b111); smp.push_back(3'b111);
         m_step = 0; m_age = 0; m_a = '0; m_b = '0; m_op = '0;
         m_err = 0; m_num = 0; m_ope = 0; m_exe = 0;
      end else begin
         p = smp[smp.size()-2] & ~smp[smp.size()-3];
         smp.push_back({btn_executar, btn_operacao, btn_numero});
         if (smp.size() > 4) void'(smp.pop_front());
         m_num = 0; m_ope = 0; m_exe = 0;
         if (m_step == 4) begin
            m_age++;
            if (ula_pronto) m_step = 0;
            else if (m_age == TIMEOUT) begin m_err = 1; m_step = 0; end
         end else if (p != 3'b000) begin
            if (m_step == 0 && p == 3'b001) begin m_a = dado_in; m_num = 1; m_err = 0; m_step = 1; end
            else if (m_step == 1 && p == 3'b010) begin m_op = op_in; m_ope = 1; m_err = 0; m_step = 2; end
            else if (m_step == 2 && p == 3'b001) begin m_b = dado_in; m_num = 1; m_err = 0; m_step = 3; end
            else if (m_step == 2 && p == 3'b010) begin m_op = op_in; m_ope = 1; m_err = 0; end
            else if (m_step == 3 && p == 3'b001) begin m_b = dado_in; m_num = 1; m_err = 0; end
            else if (m_step == 3 && p == 3'b100) begin m_exe = 1; m_err = 0; m_age = 0; m_step = 4; end
            else m_err = 1;
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk_in) begin
      chk("mdl_entrada_numero", 32'(entrada_numero), 32'(m_num));
      chk("mdl_entrada_operacao", 32'(entrada_operacao), 32'(m_ope));
      chk("mdl_executar", 32'(executar), 32'(m_exe));
      chk("mdl_operando_a", 32'(operando_a), 32'(m_a));
      chk("mdl_operando_b", 32'(operando_b), 32'(m_b));
      chk("mdl_operacao", 32'(operacao), 32'(m_op));
      chk("mdl_estado", 32'(estado), 32'(m_step));
      chk("mdl_erro", 32'(erro), 32'(m_err));
   end

   // Strobe pulse counters, sampled shortly after each active edge.
   int n_num = 0, n_ope = 0, n_exe = 0;
   always @(posedge clk_in) begin
      #2;
      if (entrada_numero)   n_num++;
      if (entrada_operacao) n_ope++;
      if (executar)         n_exe++;
   end

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   // Hold one button for 3 edges, then release it for 3 edges. The strobe happens during the hold.
   task automatic press_btn(input int b, input logic [7:0] d, input logic [2:0] o);
      dado_in = d;
      op_in   = o;
      case (b)
         0: btn_numero   = 1'b1;
         1: btn_operacao = 1'b1;
         default: btn_executar = 1'b1;
      endcase
      repeat (3) tick();
      btn_numero = 1'b0; btn_operacao = 1'b0; btn_executar = 1'b0;
      repeat (3) tick();
   endtask

   int c_num, c_ope, c_exe;

   initial begin
      rst = 1'b1;
      btn_numero = 0; btn_operacao = 0; btn_executar = 0;
      dado_in = '0; op_in = '0; ula_pronto = 0;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      chk("reset_estado", 32'(estado), 32'd0);
      chk("reset_erro", 32'(erro), 32'd0);
      chk("reset_operando_a", 32'(operando_a), 32'd0);
      chk("reset_operando_b", 32'(operando_b), 32'd0);
      chk("reset_operacao", 32'(operacao), 32'd0);

      // Happy path
      c_num = n_num; c_ope = n_ope; c_exe = n_exe;
      press_btn(0, 8'h2A, 3'd0);
      chk("happy_a", 32'(operando_a), 32'h2A);
      chk("happy_estado1", 32'(estado), 32'd1);
      press_btn(1, 8'h00, 3'd3);
      chk("happy_op", 32'(operacao), 32'd3);
      chk("happy_estado2", 32'(estado), 32'd2);
      press_btn(0, 8'h05, 3'd0);
      chk("happy_b", 32'(operando_b), 32'h05);
      chk("happy_estado3", 32'(estado), 32'd3);
      press_btn(2, 8'h00, 3'd0);
      chk("happy_estado4", 32'(estado), 32'd4);
      ula_pronto = 1'b1;
      tick();
      ula_pronto = 1'b0;
      chk("happy_estado0", 32'(estado), 32'd0);
      chk("happy_erro", 32'(erro), 32'd0);
      chk("happy_n_num", 32'(n_num - c_num), 32'd2);
      chk("happy_n_ope", 32'(n_ope - c_ope), 32'd1);
      chk("happy_n_exe", 32'(n_exe - c_exe), 32'd1);
      chk("happy_a_hold", 32'(operando_a), 32'h2A);

      // Latency and width: hold numero for 20 cycles
      do_reset();
      c_num = n_num;
      dado_in = 8'h77;
      btn_numero = 1'b1;
      repeat (2) tick();
      chk("lat_before", 32'(entrada_numero), 32'd0);
      tick();
      chk("lat_at3", 32'(entrada_numero), 32'd1);
      repeat (17) tick();
      btn_numero = 1'b0;
      repeat (3) tick();
      chk("width_count", 32'(n_num - c_num), 32'd1);
      chk("lat_a", 32'(operando_a), 32'h77);

      // Out of order
      do_reset();
      c_exe = n_exe;
      press_btn(2, 8'h00, 3'd0);
      chk("ooo_erro", 32'(erro), 32'd1);
      chk("ooo_no_exe", 32'(n_exe - c_exe), 32'd0);
      chk("ooo_estado", 32'(estado), 32'd0);
      press_btn(0, 8'h11, 3'd0);
      chk("ooo_erro_clr", 32'(erro), 32'd0);
      chk("ooo_a", 32'(operando_a), 32'h11);
      chk("ooo_estado1", 32'(estado), 32'd1);

      // Simultaneous presses
      do_reset();
      c_num = n_num; c_ope = n_ope;
      btn_numero = 1'b1; btn_operacao = 1'b1;
      repeat (3) tick();
      btn_numero = 1'b0; btn_operacao = 1'b0;
      repeat (3) tick();
      chk("sim_erro", 32'(erro), 32'd1);
      chk("sim_estado", 32'(estado), 32'd0);
      chk("sim_strobes", 32'((n_num - c_num) + (n_ope - c_ope)), 32'd0);

      // Timeout without ula_pronto
      do_reset();
      press_btn(0, 8'h01, 3'd0);
      press_btn(1, 8'h00, 3'd2);
      press_btn(0, 8'h02, 3'd0);
      btn_executar = 1'b1;
      repeat (3) tick();
      chk("to_exe", 32'(executar), 32'd1);
      chk("to_in_exec", 32'(estado), 32'd4);
      btn_executar = 1'b0;
      repeat (15) tick();
      chk("to_edge15", 32'(estado), 32'd4);
      tick();
      chk("to_edge16_estado", 32'(estado), 32'd0);
      chk("to_edge16_erro", 32'(erro), 32'd1);

      // ula_pronto on the same edge as the timeout
      press_btn(0, 8'h03, 3'd0);
      chk("to2_erro_clr", 32'(erro), 32'd0);
      press_btn(1, 8'h00, 3'd1);
      press_btn(0, 8'h04, 3'd0);
      btn_executar = 1'b1;
      repeat (3) tick();
      btn_executar = 1'b0;
      repeat (15) tick();
      chk("to2_edge15", 32'(estado), 32'd4);
      ula_pronto = 1'b1;
      tick();
      ula_pronto = 1'b0;
      chk("to2_estado", 32'(estado), 32'd0);
      chk("to2_erro", 32'(erro), 32'd0);

      // Reset mid-operation with numero held
      do_reset();
      press_btn(0, 8'h55, 3'd0);
      press_btn(1, 8'h00, 3'd6);
      chk("rst_in_b", 32'(estado), 32'd2);
      c_num = n_num;
      dado_in = 8'h99;
      btn_numero = 1'b1;
      repeat (2) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_estado", 32'(estado), 32'd0);
      chk("rst_a", 32'(operando_a), 32'd0);
      chk("rst_op", 32'(operacao), 32'd0);
      chk("rst_strobe", 32'(entrada_numero), 32'd0);
      repeat (10) tick();
      chk("rst_held_no_press", 32'(n_num - c_num), 32'd0);
      btn_numero = 1'b0;
      repeat (3) tick();
      press_btn(0, 8'h33, 3'd0);
      chk("rst_repress_a", 32'(operando_a), 32'h33);
      chk("rst_repress_cnt", 32'(n_num - c_num), 32'd1);

      repeat (2) tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
